// File: rtl/uart_tx_core_if.sv
// -----------------------------------------------------------------------------
// uart_tx_core_if
// Word-side handshake bundle for uart_tx_core.
//
// Signals:
//   P_DATA     word to transmit (master -> core)
//   Data_Valid level request, held until Data_Ack (master -> core)
//   PAR_EN     1 = append parity bit (master -> core)
//   PAR_TYP    0 = even, 1 = odd parity (master -> core)
//   STOP2      0 = one stop bit, 1 = two stop bits (master -> core)
//   busy       frame on the line (core -> master)
//   Data_Ack   one-cycle pulse after a word is accepted (core -> master)
//   hold_full  holding register occupied (core -> master)
//
// Modports: master (word producer), slave (the transmitter core).
// -----------------------------------------------------------------------------
interface uart_tx_core_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  busy;
  logic                  Data_Ack;
  logic                  hold_full;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    input  busy, Data_Ack, hold_full
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    output busy, Data_Ack, hold_full
  );
endinterface

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// UART transmitter, one frame bit per CLK cycle. Frame = start bit, DATA_WIDTH
// data bits LSB first, optional parity bit, one or two stop bits. A word
// accepted in the last stop cycle starts immediately, so frames can run
// back-to-back with no idle gap.
//
// Ports:
//   CLK     bit-rate clock, rising edge
//   RST     synchronous active-low reset
//   bus     uart_tx_core_if.slave word handshake (P_DATA, Data_Valid, PAR_EN,
//           PAR_TYP, STOP2 in; busy, Data_Ack, hold_full out)
//   TX_OUT  serial line, idle high
//
// Build option:
//   UART_TX_HOLD_REG_EN  when defined, adds a one-word holding register
//                        (data + frame configuration) so the next word can be
//                        accepted while a frame is still on the line.
//                        Undefined: hold_full is tied to 0 and requests made
//                        mid-frame wait for the last stop cycle.
// -----------------------------------------------------------------------------
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_core_if.slave  bus,
  output logic           TX_OUT
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  par_en_reg, par_en_next;
  logic                  stop2_reg, stop2_next;
  logic                  ack_reg, ack_next;

  logic                  last_stop;
  logic                  req;
  logic                  launch_new;
  logic                  launch_held;
  logic                  launch;
  logic                  capture;

  // Word/configuration that gets loaded into the frame registers on launch.
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_par_en;
  logic                  src_par_typ;
  logic                  src_stop2;

  assign last_stop = ((state_reg == ST_STOP1) && !stop2_reg) ||
                     (state_reg == ST_STOP2);

  // While Data_Ack is high the master has not yet had an edge to drop or
  // change its request, so the request seen on that edge is the word that
  // was just taken and must not be accepted a second time.
  assign req = bus.Data_Valid && !ack_reg;

  // Parity of the word being launched, built as an XOR chain.
  logic [DATA_WIDTH:0] par_chain;
  assign par_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ src_data[gi];
    end
  endgenerate

`ifdef UART_TX_HOLD_REG_EN
  logic [DATA_WIDTH-1:0] hold_data_reg, hold_data_next;
  logic                  hold_par_en_reg, hold_par_en_next;
  logic                  hold_par_typ_reg, hold_par_typ_next;
  logic                  hold_stop2_reg, hold_stop2_next;
  logic                  hold_full_reg, hold_full_next;

  always_comb begin
    // A held word always goes out before a fresh request.
    launch_held = last_stop && hold_full_reg;
    launch_new  = req && !launch_held &&
                  ((state_reg == ST_IDLE) || last_stop);
    // Fill the holding register mid-frame, or refill it in the same cycle
    // the held word is launched.
    capture     = req && (((state_reg != ST_IDLE) && !last_stop && !hold_full_reg) ||
                          launch_held);

    hold_data_next    = hold_data_reg;
    hold_par_en_next  = hold_par_en_reg;
    hold_par_typ_next = hold_par_typ_reg;
    hold_stop2_next   = hold_stop2_reg;
    hold_full_next    = hold_full_reg;
    if (capture) begin
      hold_data_next    = bus.P_DATA;
      hold_par_en_next  = bus.PAR_EN;
      hold_par_typ_next = bus.PAR_TYP;
      hold_stop2_next   = bus.STOP2;
      hold_full_next    = 1'b1;
    end else if (launch_held) begin
      hold_full_next    = 1'b0;
    end

    if (launch_held) begin
      src_data    = hold_data_reg;
      src_par_en  = hold_par_en_reg;
      src_par_typ = hold_par_typ_reg;
      src_stop2   = hold_stop2_reg;
    end else begin
      src_data    = bus.P_DATA;
      src_par_en  = bus.PAR_EN;
      src_par_typ = bus.PAR_TYP;
      src_stop2   = bus.STOP2;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_data_reg    <= '0;
      hold_par_en_reg  <= 1'b0;
      hold_par_typ_reg <= 1'b0;
      hold_stop2_reg   <= 1'b0;
      hold_full_reg    <= 1'b0;
    end else begin
      hold_data_reg    <= hold_data_next;
      hold_par_en_reg  <= hold_par_en_next;
      hold_par_typ_reg <= hold_par_typ_next;
      hold_stop2_reg   <= hold_stop2_next;
      hold_full_reg    <= hold_full_next;
    end
  end

  assign bus.hold_full = hold_full_reg;
`else
  assign launch_held   = 1'b0;
  assign capture       = 1'b0;
  assign launch_new    = req && ((state_reg == ST_IDLE) || last_stop);
  assign src_data      = bus.P_DATA;
  assign src_par_en    = bus.PAR_EN;
  assign src_par_typ   = bus.PAR_TYP;
  assign src_stop2     = bus.STOP2;
  assign bus.hold_full = 1'b0;
`endif

  assign launch = launch_new || launch_held;

  // Next-state and frame register updates.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    par_bit_next = par_bit_reg;
    par_en_next  = par_en_reg;
    stop2_next   = stop2_reg;
    ack_next     = launch_new || capture;

    case (state_reg)
      ST_IDLE: begin
        if (launch) state_next = ST_START;
      end
      ST_START: begin
        state_next   = ST_DATA;
        bit_cnt_next = '0;
      end
      ST_DATA: begin
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_next = '0;
          state_next   = par_en_reg ? ST_PARITY : ST_STOP1;
        end else begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        state_next = ST_STOP1;
      end
      ST_STOP1: begin
        if (stop2_reg)   state_next = ST_STOP2;
        else if (launch) state_next = ST_START;
        else             state_next = ST_IDLE;
      end
      ST_STOP2: begin
        state_next = launch ? ST_START : ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = '0;
      end
    endcase

    // launch only occurs in IDLE or the last stop cycle, so loading here
    // never disturbs a frame in progress.
    if (launch) begin
      data_next    = src_data;
      par_bit_next = par_chain[DATA_WIDTH] ^ src_par_typ;
      par_en_next  = src_par_en;
      stop2_next   = src_stop2;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      par_bit_reg <= 1'b0;
      par_en_reg  <= 1'b0;
      stop2_reg   <= 1'b0;
      ack_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      data_reg    <= data_next;
      par_bit_reg <= par_bit_next;
      par_en_reg  <= par_en_next;
      stop2_reg   <= stop2_next;
      ack_reg     <= ack_next;
    end
  end

  // Line level is decoded purely from registered state.
  always_comb begin
    TX_OUT = 1'b1;
    case (state_reg)
      ST_START:  TX_OUT = 1'b0;
      ST_DATA:   TX_OUT = data_reg[bit_cnt_reg];
      ST_PARITY: TX_OUT = par_bit_reg;
      default:   TX_OUT = 1'b1;
    endcase
  end

  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.Data_Ack = ack_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Bench for uart_tx_core (DATA_WIDTH = 8). A bit-queue model predicts the line,
// busy, Data_Ack and hold_full every cycle; directed frames are also checked
// against hand-written bit sequences. Works with or without
// UART_TX_HOLD_REG_EN defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic TX_OUT;

  uart_tx_core_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus    (bus),
    .TX_OUT (TX_OUT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Frame as a bit vector, first bit on the line at index n-1.
  function automatic logic [15:0] frame_vec(input logic [DW-1:0] w, input logic pe,
                                            input logic pt, input logic s2, output int n);
    logic [15:0] v;
    v = '0;
    n = 0;
    v = {v[14:0], 1'b0}; n++;
    for (int i = 0; i < DW; i++) begin
      v = {v[14:0], w[i]}; n++;
    end
    if (pe) begin
      v = {v[14:0], (^w) ^ pt}; n++;
    end
    v = {v[14:0], 1'b1}; n++;
    if (s2) begin
      v = {v[14:0], 1'b1}; n++;
    end
    return v;
  endfunction

  bit            mq[$];     // bits still to appear on the line, head = this cycle
  bit            m_ack   = 1'b0;
  bit            m_held  = 1'b0;
  bit            model_on = 1'b0;
  logic [DW-1:0] h_w;
  logic          h_pe, h_pt, h_s2;

  task automatic push_frame(input logic [DW-1:0] w, input logic pe, input logic pt, input logic s2);
    int n;
    logic [15:0] v;
    v = frame_vec(w, pe, pt, s2, n);
    for (int k = n - 1; k >= 0; k--) mq.push_back(v[k]);
  endtask

  task automatic model_step();
    bit idle, last, req, nack;
    if (!RST) begin
      mq.delete();
      m_ack    = 1'b0;
      m_held   = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      idle = (mq.size() == 0);
      last = (mq.size() == 1);
      req  = bus.Data_Valid && !m_ack;
      nack = 1'b0;
      if (!idle) void'(mq.pop_front());
`ifdef UART_TX_HOLD_REG_EN
      if (last && m_held) begin
        push_frame(h_w, h_pe, h_pt, h_s2);
        m_held = 1'b0;
        if (req) begin
          h_w = bus.P_DATA; h_pe = bus.PAR_EN; h_pt = bus.PAR_TYP; h_s2 = bus.STOP2;
          m_held = 1'b1;
          nack   = 1'b1;
        end
      end else if (req && (idle || last)) begin
        push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.STOP2);
        nack = 1'b1;
      end else if (req && !m_held) begin
        h_w = bus.P_DATA; h_pe = bus.PAR_EN; h_pt = bus.PAR_TYP; h_s2 = bus.STOP2;
        m_held = 1'b1;
        nack   = 1'b1;
      end
`else
      if (req && (idle || last)) begin
        push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.STOP2);
        nack = 1'b1;
      end
`endif
      m_ack = nack;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Compare process: every cycle once the model has seen reset.
  initial forever begin
    @(negedge CLK);
    if (model_on) begin
      chk("model_tx_out", TX_OUT, (mq.size() == 0) ? 1'b1 : mq[0]);
      chk("model_busy", bus.busy, mq.size() != 0);
      chk("model_data_ack", bus.Data_Ack, m_ack);
      chk("model_hold_full", bus.hold_full, m_held);
      if (bus.Data_Ack === 1'b1) $display("accept pulse t=%0t", $time);
    end
  end

  // ------------------------------------------------------------- directed
  task automatic run_frame(input string name, input logic [DW-1:0] w, input logic pe,
                           input logic pt, input logic s2, input int n, input logic [15:0] exp_seq);
    logic [15:0] seq;
    int          acks;
    logic        busy_all;
    @(posedge CLK); #1;
    bus.P_DATA = w; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.STOP2 = s2;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    // Word taken; scramble the inputs to show they no longer matter.
    bus.Data_Valid = 1'b0;
    bus.P_DATA = ~w; bus.PAR_EN = ~pe; bus.PAR_TYP = ~pt; bus.STOP2 = ~s2;
    seq = '0; acks = 0; busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      seq = {seq[14:0], TX_OUT};
      if (bus.Data_Ack === 1'b1) acks++;
      busy_all = busy_all & bus.busy;
    end
    @(negedge CLK);
    chk({name, "_seq"}, seq, exp_seq);
    chk({name, "_acks"}, acks, 1);
    chk({name, "_busy"}, busy_all, 1'b1);
    chk({name, "_idle_tx"}, TX_OUT, 1'b1);
    chk({name, "_idle_busy"}, bus.busy, 1'b0);
    $display("frame %s word=%h pe=%0d pt=%0d s2=%0d line=%b", name, w, pe, pt, s2, seq);
  endtask

  logic [DW-1:0] words [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int          n;
    int          acks, idx;
    logic [15:0] v;
    logic [31:0] seq32, mask;
    logic        busy_all, hf5;

    bus.P_DATA = '0; bus.Data_Valid = 1'b0;
    bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.STOP2 = 1'b0;

    // Pin the model to hand-computed frames.
    v = frame_vec(8'hA5, 1'b1, 1'b0, 1'b0, n);
    chk("pin_a5_len", n, 11);
    chk("pin_a5_bits", v[10:0], 11'b01010010101);
    v = frame_vec(8'h01, 1'b1, 1'b1, 1'b0, n);
    chk("pin_01_odd_parity", v[1], 1'b0);
    v = frame_vec(8'h03, 1'b1, 1'b1, 1'b0, n);
    chk("pin_03_odd_parity", v[1], 1'b1);
    v = frame_vec(8'h03, 1'b0, 1'b0, 1'b1, n);
    chk("pin_03_s2_len", n, 11);
    chk("pin_03_s2_bits", v[10:0], 11'b01100000011);

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx_out", TX_OUT, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_data_ack", bus.Data_Ack, 1'b0);
    chk("rst_hold_full", bus.hold_full, 1'b0);
    RST = 1'b1;
    $display("reset released t=%0t", $time);

    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 11, 16'b01010010101);
    run_frame("01_odd", 8'h01, 1'b1, 1'b1, 1'b0, 11, 16'b01000000001);
    run_frame("03_odd", 8'h03, 1'b1, 1'b1, 1'b0, 11, 16'b01100000011);
    run_frame("03_stop2", 8'h03, 1'b0, 1'b0, 1'b1, 11, 16'b01100000011);

    // Reset during data bit 3 abandons the frame.
    @(posedge CLK); #1;
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.STOP2 = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("midrst_bit3", TX_OUT, 1'b0);
    chk("midrst_busy_before", bus.busy, 1'b1);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_tx_out", TX_OUT, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_data_ack", bus.Data_Ack, 1'b0);
    $display("mid-frame reset t=%0t", $time);
    run_frame("a5_after_rst", 8'hA5, 1'b1, 1'b0, 1'b0, 11, 16'b01010010101);

    // Two words with Data_Valid held: no idle gap between frames.
    @(posedge CLK); #1;
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.STOP2 = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.P_DATA = 8'hAA;
    seq32 = '0; acks = 0; busy_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      seq32 = {seq32[30:0], TX_OUT};
      busy_all = busy_all & bus.busy;
      if (bus.Data_Ack === 1'b1) begin
        acks++;
        if (acks == 2) bus.Data_Valid = 1'b0;
      end
    end
    @(negedge CLK);
    chk("b2b_seq", seq32, 32'b0101010101_0010101011);
    chk("b2b_busy", busy_all, 1'b1);
    chk("b2b_acks", acks, 2);
    chk("b2b_idle_after", bus.busy, 1'b0);
    $display("back-to-back 55,AA line=%b", seq32[19:0]);

    // Three requests issued during the first frame.
    @(posedge CLK); #1;
    bus.P_DATA = words[0]; bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    seq32 = '0; mask = '0; idx = 0; busy_all = 1'b1; hf5 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      seq32 = {seq32[30:0], TX_OUT};
      busy_all = busy_all & bus.busy;
      if (i == 5) hf5 = bus.hold_full;
      if (bus.Data_Ack === 1'b1) begin
        mask[i] = 1'b1;
        idx++;
        if (idx < 3) bus.P_DATA = words[idx];
        else         bus.Data_Valid = 1'b0;
      end
    end
    @(negedge CLK);
    chk("three_seq", seq32, 32'b0100010001_0010001001_0110011001);
    chk("three_busy", busy_all, 1'b1);
`ifdef UART_TX_HOLD_REG_EN
    chk("three_ack_cycles", mask, 32'h0000_0405);
    chk("three_hold_full_mid", hf5, 1'b1);
`else
    chk("three_ack_cycles", mask, 32'h0010_0401);
    chk("three_hold_full_mid", hf5, 1'b0);
`endif
    chk("three_idle_after", bus.busy, 1'b0);
    $display("three words 11,22,33 line=%b acks=%h", seq32[29:0], mask);

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 CLK  input  1  bit-rate clock; one frame bit per CLK cycle; all logic on rising edge.
REQ-003 RST  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 P_DATA  input  DATA_WIDTH  word to transmit; sampled only on an accept edge.
REQ-005 Data_Valid  input  1  request to transmit P_DATA; level, held until Data_Ack.
REQ-006 PAR_EN  input  1  1 = append parity bit.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 STOP2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 TX_OUT  output  1  serial line; idle high.
REQ-010 busy  output  1  high while a frame is on the line.
REQ-011 Data_Ack  output  1  one-cycle pulse in the cycle after a word is accepted.
REQ-012 hold_full  output  1  holding register occupied; constant 0 when the holding register is compiled out.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2; TX_OUT SHALL be 1, 0, current data bit, parity bit, 1 and 1 respectively.
REQ-014 Accept edge: rising edge with Data_Valid=1 in IDLE or in the last stop cycle; P_DATA, PAR_EN, PAR_TYP and STOP2 SHALL be latched; Data_Ack SHALL be 1 in the next cycle only.
REQ-015 START SHALL be driven in the cycle immediately after the accept edge; latency from Data_Valid to start bit is one cycle.
REQ-016 DATA SHALL last DATA_WIDTH cycles, LSB first, using a bit counter of width clog2(DATA_WIDTH) that wraps to 0 on leaving DATA.
REQ-017 From DATA: go to PARITY if latched PAR_EN=1, else STOP1; PARITY lasts one cycle and then goes to STOP1.
REQ-018 Parity bit SHALL be XOR of the latched word for even parity and its inverse for odd parity.
REQ-019 From STOP1: go to STOP2 if latched STOP2=1. Otherwise STOP1 is the last stop cycle. STOP2 is always the last stop cycle.
REQ-020 After the last stop cycle: go to START with no idle gap if a word is accepted on that edge, else go to IDLE.
REQ-021 busy SHALL be 0 in IDLE and 1 in all other states; busy stays 1 across back-to-back frames.
REQ-022 Frame length SHALL be 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) cycles.
REQ-023 Input changes to PAR_EN, PAR_TYP, STOP2 or P_DATA during a frame SHALL NOT affect that frame.

Reset
REQ-024 On a rising edge with RST=0, the block SHALL reset regardless of state, and any frame in progress SHALL be abandoned.
REQ-025 Reset values: state IDLE, TX_OUT=1, busy=0, Data_Ack=0, hold_full=0, bit counter 0, holding register emptied.
REQ-026 The first accept edge after RST returns to 1 SHALL behave as in REQ-014.

Configuration
REQ-027 Macro UART_TX_HOLD_REG_EN, when defined, SHALL add a one-word holding register (data and configuration).
- While busy, not in the last stop cycle, with hold_full=0 and Data_Valid=1: the word is captured into the holding register, Data_Ack pulses and hold_full is set.
- On the last stop cycle with hold_full=1: the held word is launched into START, and it takes priority over Data_Valid.
- In that same cycle, if Data_Valid=1, the new word is captured into the holding register, Data_Ack pulses and hold_full stays 1.
- Otherwise hold_full clears.
REQ-028 When UART_TX_HOLD_REG_EN is not defined:
- Data_Valid while busy is ignored outside the last stop cycle, with no Data_Ack.
- hold_full is tied to 0.

Verification
REQ-029 DATA_WIDTH=8, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; busy=1 for those 11 cycles; Data_Ack pulses once.
REQ-030 P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; P_DATA=8'h03, PAR_EN=1, PAR_TYP=1 -> parity bit 1.
REQ-031 P_DATA=8'h03, PAR_EN=0, STOP2=1 -> TX_OUT = 0,1,1,0,0,0,0,0,0,1,1; frame is 11 cycles.
REQ-032 Data_Valid held high for two words 8'h55 and 8'hAA, hold register compiled out -> second start bit directly follows the stop bit with no idle cycle; busy never drops; two Data_Ack pulses.
REQ-033 RST=0 during DATA bit 3 -> next cycle TX_OUT=1, busy=0, state IDLE; a later request with 8'hA5 yields the REQ-029 sequence.
REQ-034 UART_TX_HOLD_REG_EN defined: three requests 8'h11, 8'h22, 8'h33 issued during the first frame -> 8'h22 is held (hold_full=1) and 8'h33 gets no Data_Ack until the 8'h11 last stop cycle; the three frames go out back-to-back in order.
